bitstream_reader: RTL

- Inverse of the bitstream packer: accepts 32-bit packed words and returns variable-length fields of 0..32 bits in the order they were packed, MSB-first.
- Sits on the decode/readback side of the capture pipeline, between the word source (FIFO/DMA) and the field parser.
- Tracks the byte-alignment remainder (`rest`) exactly as the packer does, so parsers can skip padding with an align request.

---
 rtl/bitstream_reader.sv | 106 ++++++++++
 1 files changed

// File: rtl/bitstream_reader.sv
// Unpacks MSB-first variable-length fields (0..32 bits) from a stream of 32-bit words.
// Keeps the byte-alignment remainder so parsers can skip padding with an align request.
module bitstream_reader #(
  parameter int MAXLEN = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ivalid,
  input  logic [MAXLEN-1:0]             idata,
  output logic                          iready,
  input  logic                          req_valid,
  input  logic [$clog2(MAXLEN):0]       req_length,
  input  logic                          req_align,
  output logic                          req_ready,
  output logic                          ovalid,
  output logic [MAXLEN-1:0]             odata,
  output logic [2:0]                    rest,
  output logic [$clog2(2*MAXLEN):0]     level
);

  localparam int BUF_W = 2 * MAXLEN;
  localparam int LEN_W = $clog2(MAXLEN) + 1;
  localparam int LVL_W = $clog2(BUF_W) + 1;

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [2:0]        pos_q, pos_d;
  logic              ovalid_q, ovalid_d;
  logic [MAXLEN-1:0] odata_q, odata_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  consume;
  logic [LVL_W-1:0]  level_after;
  logic [MAXLEN-1:0] field;
  logic              fire;
  logic              accept;

  // Bits still needed to reach the next byte boundary.
  assign rest = 3'd0 - pos_q;

  // NOTE: every always_comb output gets a default at the top, so no path can infer a latch.
  always_comb begin
    len_clamped = req_length;
    eff_len     = '0;
    fire        = 1'b0;
    consume     = '0;
    level_after = level_q;
    accept      = 1'b0;
    field       = '0;
    buf_d       = buf_q;
    level_d     = level_q;
    pos_d       = pos_q;
    ovalid_d    = 1'b0;
    odata_d     = odata_q;

    if (req_length > LEN_W'(MAXLEN))
      len_clamped = LEN_W'(MAXLEN);
    eff_len = req_align ? LEN_W'(rest) : len_clamped;

    // Requests only see the registered level, never a word arriving this cycle.
    fire        = req_valid & (level_q >= LVL_W'(eff_len));
    consume     = fire ? eff_len : '0;
    level_after = level_q - LVL_W'(consume);
    accept      = ivalid & (level_after <= LVL_W'(MAXLEN));

    // A shift by the full width yields zero, which covers the L=0 case.
    field = buf_q[BUF_W-1 -: MAXLEN] >> (LEN_W'(MAXLEN) - eff_len);

    buf_d = buf_q << consume;
    if (accept)
      buf_d = buf_d | ({idata, {MAXLEN{1'b0}}} >> level_after);
    level_d = level_after + (accept ? LVL_W'(MAXLEN) : '0);
    pos_d   = pos_q + consume[2:0];

    ovalid_d = fire & ~req_align;
    if (ovalid_d)
      odata_d = field;
  end

  // NOTE: the shift buffer is ordinary flop state (not a RAM), so it is cleared on reset
  // to keep the invalid tail at zero for the OR-based append.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      level_q  <= '0;
      pos_q    <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates from the same pre-edge values.
      buf_q    <= buf_d;
      level_q  <= level_d;
      pos_q    <= pos_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  assign req_ready = fire;
  assign iready    = level_after <= LVL_W'(MAXLEN);
  assign ovalid    = ovalid_q;
  assign odata     = odata_q;
  assign level     = level_q;

endmodule
